// File: rtl/adder_share_pkg.sv
// Shared types and defaults for the adder-sharing arbiter and its carry-select adder.
package adder_share_pkg;

  localparam int WIDTH_DEFAULT   = 32;
  localparam int NUM_REQ_DEFAULT = 4;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef logic [$clog2(NUM_REQ_DEFAULT)-1:0] req_id_t;

endpackage

// File: rtl/adder_share_arbiter_csa_add.sv
// Combinational carry-select adder: low half ripples, upper half is chosen from two precomputed sums.
module csa_add #(
  parameter int WIDTH = adder_share_pkg::WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int H = WIDTH / 2;

  logic [H:0] lo;
  logic [H:0] hi0;
  logic [H:0] hi1;

  assign lo  = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};
  assign hi0 = {1'b0, a[WIDTH-1:H]} + {1'b0, b[WIDTH-1:H]};
  assign hi1 = {1'b0, a[WIDTH-1:H]} + {1'b0, b[WIDTH-1:H]} + {{H{1'b0}}, 1'b1};

  assign sum  = lo[H] ? {hi1[H-1:0], lo[H-1:0]} : {hi0[H-1:0], lo[H-1:0]};
  assign cout = lo[H] ? hi1[H] : hi0[H];

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one carry-select adder with packet locking and carry chaining across beats.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int WIDTH   = WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ-1:0]         req_cin,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_cout,
  output logic                       rsp_last
);

  localparam int IDW = $clog2(NUM_REQ);

  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   lock_id_q, lock_id_d;
  logic             carry_q, carry_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_last_q, rsp_last_d;

  logic             slot_free;
  logic             gnt_valid;
  logic [IDW-1:0]   gnt_id;
  logic [WIDTH-1:0] a_sel, b_sel, add_sum;
  logic             c_sel, last_sel, add_cout;

  assign slot_free = !rsp_valid_q || rsp_ready;

  // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    req_ready = '0;
    if (!rst && slot_free) begin
      if (state_q == LOCKED) begin
        if (req_valid[lock_id_q]) begin
          gnt_valid = 1'b1;
          gnt_id    = lock_id_q;
        end
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!gnt_valid && req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
            gnt_valid = 1'b1;
            gnt_id    = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
          end
        end
      end
    end
    req_ready[gnt_id] = gnt_valid;
  end

  assign a_sel    = req_a[int'(gnt_id)*WIDTH +: WIDTH];
  assign b_sel    = req_b[int'(gnt_id)*WIDTH +: WIDTH];
  assign c_sel    = (state_q == LOCKED) ? carry_q : req_cin[gnt_id];
  assign last_sel = req_last[gnt_id];

  csa_add #(.WIDTH(WIDTH)) u_csa_add (
    .a    (a_sel),
    .b    (b_sel),
    .cin  (c_sel),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_id_d   = lock_id_q;
    carry_d     = carry_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_last_d  = rsp_last_q;

    if (slot_free) rsp_valid_d = gnt_valid;

    if (gnt_valid) begin
      rsp_id_d   = gnt_id;
      rsp_sum_d  = add_sum;
      rsp_cout_d = add_cout;
      rsp_last_d = last_sel;
      if (state_q == ARB) begin
        rr_ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
        if (!last_sel) begin
          state_d   = LOCKED;
          lock_id_d = gnt_id;
          carry_d   = add_cout;
        end
      end else begin
        // Pointer stays put while locked so the packet owner does not skip ahead.
        carry_d = add_cout;
        if (last_sel) state_d = ARB;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      lock_id_q   <= '0;
      carry_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_id_q   <= lock_id_d;
      carry_q     <= carry_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: hand-computed sums, grant order, locking, backpressure, reset.
module tb_adder_share_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic [N-1:0]   req_last;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic           rsp_last;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_last  (req_last),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_last  (rsp_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic last);
    req_valid[i]       = 1'b1;
    req_a[i*W +: W]    = a;
    req_b[i*W +: W]    = b;
    req_cin[i]         = cin;
    req_last[i]        = last;
  endtask

  task automatic drop_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic [1:0] id, input logic [W-1:0] sum,
                           input logic cout, input logic last);
    check({tag, ".valid"}, rsp_valid, 1'b1);
    check({tag, ".id"},    rsp_id,    id);
    check({tag, ".sum"},   rsp_sum,   sum);
    check({tag, ".cout"},  rsp_cout,  cout);
    check({tag, ".last"},  rsp_last,  last);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, rsp_valid, 1'b0);
    check({tag, ".id"},    rsp_id,    2'd0);
    check({tag, ".sum"},   rsp_sum,   32'd0);
    check({tag, ".cout"},  rsp_cout,  1'b0);
    check({tag, ".last"},  rsp_last,  1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_last  = '1;
    rsp_ready = 1'b1;

    // Reset: ready must stay low even with every requester valid.
    req_valid = '1;
    tick();
    tick();
    check("reset_ready", req_ready, 4'b0000);
    req_valid = '0;
    rst = 1'b0;
    tick();
    check_idle("reset_rsp");

    // Test 1: carry propagates across the half boundary.
    set_req(0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b1);
    settle();
    check("t1_ready", req_ready, 4'b0001);
    tick();
    drop_req(0);
    check_rsp("t1", 2'd0, 32'h00010000, 1'b0, 1'b1);

    // Test 2: full overflow, then carry-in on a single-beat op.
    set_req(1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1);
    settle();
    check("t2a_ready", req_ready, 4'b0010);
    tick();
    check_rsp("t2a", 2'd1, 32'h00000000, 1'b1, 1'b1);
    set_req(1, 32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b1);
    settle();
    check("t2b_ready", req_ready, 4'b0010);
    tick();
    drop_req(1);
    check_rsp("t2b", 2'd1, 32'h80000000, 1'b0, 1'b1);
    tick();
    check("t2_drain", rsp_valid, 1'b0);

    // Re-home the round-robin pointer before the fairness sweep.
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Test 3: all four requesting; grants rotate 0,1,2,3,0,1 back to back.
    for (int i = 0; i < N; i++) set_req(i, W'(i * 16 + 1), W'(i), 1'b0, 1'b1);
    settle();
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t3_ready%0d", k), req_ready, 4'b0001 << (k % N));
      tick();
      check_rsp($sformatf("t3_rsp%0d", k), 2'(k % N), W'((k % N) * 17 + 1), 1'b0, 1'b1);
    end
    req_valid = '0;
    tick();
    check("t3_drain", rsp_valid, 1'b0);

    // Test 4: req2 (pointer now at 2) sends a 2-beat packet while req1 waits.
    set_req(1, 32'h00000005, 32'h00000005, 1'b0, 1'b1);
    set_req(2, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    settle();
    check("t4_b0_ready", req_ready, 4'b0100);
    tick();
    check_rsp("t4_b0", 2'd2, 32'h00000000, 1'b1, 1'b0);
    drop_req(2);
    settle();
    check("t4_stall_ready", req_ready, 4'b0000);
    tick();
    check("t4_stall_rsp", rsp_valid, 1'b0);
    set_req(2, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
    settle();
    check("t4_b1_ready", req_ready, 4'b0100);
    tick();
    drop_req(2);
    check_rsp("t4_b1", 2'd2, 32'h00000001, 1'b0, 1'b1);
    check("t4_req1_ready", req_ready, 4'b0010);
    tick();
    check_rsp("t4_req1", 2'd1, 32'h0000000A, 1'b0, 1'b1);

    // Test 5: backpressure holds the slot and blocks all grants.
    drop_req(1);
    rsp_ready = 1'b0;
    set_req(0, 32'h00000001, 32'h00000002, 1'b0, 1'b1);
    settle();
    check("t5_ready_hold", req_ready, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_rsp($sformatf("t5_hold%0d", k), 2'd1, 32'h0000000A, 1'b0, 1'b1);
      check($sformatf("t5_ready%0d", k), req_ready, 4'b0000);
    end
    rsp_ready = 1'b1;
    settle();
    check("t5_ready_release", req_ready, 4'b0001);
    tick();
    drop_req(0);
    check_rsp("t5_next", 2'd0, 32'h00000003, 1'b0, 1'b1);

    // Test 6: reset while locked on req3 abandons the packet and clears the lock.
    set_req(3, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
    settle();
    check("t6_b0_ready", req_ready, 4'b1000);
    tick();
    check_rsp("t6_b0", 2'd3, 32'h00000002, 1'b0, 1'b0);
    set_req(3, 32'h00000010, 32'h00000010, 1'b0, 1'b1);
    set_req(0, 32'h00000007, 32'h00000008, 1'b0, 1'b1);
    rst = 1'b1;
    settle();
    check("t6_rst_ready", req_ready, 4'b0000);
    tick();
    rst = 1'b0;
    check_idle("t6_rst_rsp");
    settle();
    check("t6_arb_ready", req_ready, 4'b0001);
    tick();
    drop_req(0);
    check_rsp("t6_req0", 2'd0, 32'h0000000F, 1'b0, 1'b1);
    check("t6_req3_ready", req_ready, 4'b1000);
    tick();
    drop_req(3);
    check_rsp("t6_req3", 2'd3, 32'h00000020, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
